// File: rtl/rp_stream_pkg.sv
// Shared types and gpio field positions
// for the reconfigurable-partition stream engine.
package rp_stream_pkg;

  typedef enum logic [1:0] {
    PASS  = 2'd0,
    ADD   = 2'd1,
    XOR   = 2'd2,
    BSWAP = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DROP = 2'd2
  } state_e;

  localparam int GPIO_MODE_LSB = 0;
  localparam int GPIO_K_LSB    = 2;

endpackage

// File: rtl/rp_stream_fifo.sv
// Synchronous FIFO with wrap-bit pointers;
// the head entry is presented combinationally.
module rp_stream_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset: pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/rp_stream_engine.sv
// AXI-Stream engine: per-packet transform,
// output FIFO, overlength truncation and irq.
module rp_stream_engine
  import rp_stream_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int GPIO_W     = 10,
  parameter int MAX_BEATS  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  input  logic [GPIO_W-1:0] gpio,
  input  logic              irq_ack,
  output logic              irq,
  output logic              ovf
);

  localparam int CW = $clog2(MAX_BEATS + 1);

  state_e            state;
  state_e            state_nx;
  mode_e             mode_q;
  mode_e             mode_live;
  mode_e             mode_use;
  logic [7:0]        k_q;
  logic [7:0]        k_live;
  logic [7:0]        k_use;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nx;
  logic [DATA_W-1:0] xf_data;
  logic              accept;
  logic              push;
  logic              push_last;
  logic              trunc;
  logic              latch;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W:0]   fifo_rdata;

  assign mode_live = mode_e'(gpio[GPIO_MODE_LSB +: 2]);
  assign k_live    = gpio[GPIO_K_LSB +: 8];

  // First beat of a packet sees live gpio.
  assign mode_use = (state == IDLE) ? mode_live : mode_q;
  assign k_use    = (state == IDLE) ? k_live : k_q;

  assign s_axis_tready = rst_n &&
                         ((state == DROP) || !fifo_full);
  assign accept = s_axis_tvalid && s_axis_tready;

  always_comb begin
    xf_data = s_axis_tdata;
    unique case (mode_use)
      PASS: xf_data = s_axis_tdata;
      ADD:  xf_data = s_axis_tdata + DATA_W'(k_use);
      XOR:  xf_data = s_axis_tdata ^ {(DATA_W/8){k_use}};
      BSWAP: begin
        for (int i = 0; i < DATA_W/8; i++)
          xf_data[8*i +: 8] =
            s_axis_tdata[DATA_W-8-8*i +: 8];
      end
      default: xf_data = s_axis_tdata;
    endcase
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    push      = 1'b0;
    push_last = s_axis_tlast;
    trunc     = 1'b0;
    latch     = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          push  = 1'b1;
          latch = 1'b1;
          if (!s_axis_tlast) begin
            state_nx = RUN;
            cnt_nx   = CW'(1);
          end
        end
      end
      RUN: begin
        if (accept) begin
          push = 1'b1;
          if (s_axis_tlast) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else if (cnt == CW'(MAX_BEATS - 1)) begin
            push_last = 1'b1;
            trunc     = 1'b1;
            state_nx  = DROP;
            cnt_nx    = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      DROP: begin
        if (accept && s_axis_tlast) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      mode_q <= PASS;
      k_q    <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (latch) begin
        mode_q <= mode_live;
        k_q    <= k_live;
      end
    end
  end

  // Set beats acknowledge when both land together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
        irq <= 1'b1;
      else if (irq_ack)
        irq <= 1'b0;
      if (trunc)
        ovf <= 1'b1;
      else if (irq_ack)
        ovf <= 1'b0;
    end
  end

  rp_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({push_last, xf_data}),
    .pop   (m_axis_tready),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_rdata[DATA_W-1:0];
  assign m_axis_tlast  = fifo_rdata[DATA_W];

endmodule
